// File: rtl/jpeg_lane_inserter.sv
// jpeg_lane_inserter
//   Buffers a JPEG byte stream in a synchronous FIFO and substitutes the bytes
//   into the user-data slots of a MAC transmit lane stream (4-bit nibble lanes
//   or 8-bit byte lanes). Pads with PAD_BYTE on underflow, flushes image tails
//   via start_send, and reports eof/split events and status counters.
//
// Ports
//   eth_clk, rst        : sole clock, synchronous active-high reset
//   in_valid/in_data/in_eof/in_ready : JPEG byte write side (in_ready = !full, combinational)
//   lane_in/lane_user/lane_valid     : framer lane stream
//   lane_out/lane_out_valid          : lane stream with payload substituted (PIPE_DLY+1 latency)
//   start_send          : request the framer to begin a frame
//   eof_sent            : pulse with the last lane word of an eof byte
//   split_err           : pulse when a frame ends between the two nibbles of a byte
//   underflow_cnt       : saturating count of padded bytes
//   fill_level          : FIFO occupancy
//
// Legal parameter ranges: LANE_W is 4 or 8, PIPE_DLY is at least 2.

module jpeg_lane_inserter #(
   parameter int unsigned LANE_W       = 4,
   parameter int unsigned DEPTH_LOG2   = 12,
   parameter int unsigned START_THRESH = 1024,
   parameter int unsigned PIPE_DLY     = 2,
   parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
   input  logic                  eth_clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   input  logic                  in_eof,
   output logic                  in_ready,
   input  logic [LANE_W-1:0]     lane_in,
   input  logic                  lane_user,
   input  logic                  lane_valid,
   output logic                  start_send,
   output logic [LANE_W-1:0]     lane_out,
   output logic                  lane_out_valid,
   output logic                  eof_sent,
   output logic                  split_err,
   output logic [15:0]           underflow_cnt,
   output logic [DEPTH_LOG2:0]   fill_level
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
   localparam bit          WIDE  = (LANE_W == 8);

   // FIFO storage and bookkeeping
   logic [8:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      eof_pend;
   logic                  wr_en;
   logic                  empty;
   logic                  deq;
   logic [8:0]            fifo_head;

   // lane delay line, index k holds stage d[k]
   logic [LANE_W-1:0]     d_lane [1:PIPE_DLY];
   logic [PIPE_DLY:1]     d_user;
   logic [PIPE_DLY:1]     d_valid;

   // substitution state
   logic [8:0]            head;       // {eof, byte} currently being emitted
   logic                  phase;      // nibble phase of the word at d[PIPE_DLY]
   logic                  phase_next; // phase seen by the word at d[PIPE_DLY-1]
   logic                  slot_sub;
   logic                  slot_pre;
   logic                  need_byte;
   logic [7:0]            sub_byte;
   logic [LANE_W-1:0]     lane_next;
   logic                  eof_next;
   logic                  split_next;
   logic                  start_next;

   assign in_ready   = (count != CNT_W'(DEPTH));
   assign wr_en      = in_valid & in_ready;
   assign empty      = (count == '0);
   assign fifo_head  = mem[rd_ptr];
   assign fill_level = count;

   assign slot_sub = d_valid[PIPE_DLY] & d_user[PIPE_DLY];
   assign slot_pre = d_valid[PIPE_DLY-1] & d_user[PIPE_DLY-1];

   // Phase the next word will see once it reaches the substitution stage;
   // a byte is fetched one stage early so head is ready at substitution.
   always_comb begin
      phase_next = phase;
      if (!d_valid[PIPE_DLY]) begin
         phase_next = 1'b0;
      end else if (d_user[PIPE_DLY] && !WIDE) begin
         phase_next = ~phase;
      end
      need_byte = slot_pre & (WIDE | ~phase_next);
      deq       = need_byte & ~empty;
   end

   // Lane substitution and status pulses for the word at d[PIPE_DLY]
   always_comb begin
      sub_byte   = (!WIDE && phase) ? (head[7:0] >> 4) : head[7:0];
      lane_next  = d_lane[PIPE_DLY];
      eof_next   = 1'b0;
      if (slot_sub) begin
         lane_next = LANE_W'(sub_byte);
         eof_next  = head[8] & (WIDE | phase);
      end
      // frame ended on the cycle before: lane_out_valid still holds the old valid
      split_next = ~d_valid[PIPE_DLY] & lane_out_valid & phase & ~WIDE;
      start_next = ~d_valid[PIPE_DLY] &
                   ((count >= CNT_W'(START_THRESH)) | (eof_pend != '0));
   end

   // FIFO memory, no reset needed: contents are qualified by count
   always_ff @(posedge eth_clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {in_eof, in_data};
      end
   end

   // Pointers, counters, lane pipeline and registered outputs
   always_ff @(posedge eth_clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         eof_pend       <= '0;
         head           <= '0;
         phase          <= 1'b0;
         d_user         <= '0;
         d_valid        <= '0;
         for (int k = 1; k <= int'(PIPE_DLY); k++) begin
            d_lane[k] <= '0;
         end
         lane_out       <= '0;
         lane_out_valid <= 1'b0;
         eof_sent       <= 1'b0;
         split_err      <= 1'b0;
         start_send     <= 1'b0;
         underflow_cnt  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (deq) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
         if (wr_en && !deq) begin
            count <= count + CNT_W'(1);
         end else if (deq && !wr_en) begin
            count <= count - CNT_W'(1);
         end

         // eof entries in flight; simultaneous inc/dec cancels
         if ((wr_en && in_eof) && !(deq && fifo_head[8])) begin
            eof_pend <= eof_pend + CNT_W'(1);
         end else if ((deq && fifo_head[8]) && !(wr_en && in_eof)) begin
            eof_pend <= eof_pend - CNT_W'(1);
         end

         if (need_byte) begin
            if (!empty) begin
               head <= fifo_head;
            end else begin
               head <= {1'b0, PAD_BYTE};
               if (underflow_cnt != 16'hFFFF) begin
                  underflow_cnt <= underflow_cnt + 16'd1;
               end
            end
         end

         phase   <= phase_next;
         d_valid <= {d_valid[PIPE_DLY-1:1], lane_valid};
         d_user  <= {d_user[PIPE_DLY-1:1], lane_user};
         d_lane[1] <= lane_in;
         for (int k = 2; k <= int'(PIPE_DLY); k++) begin
            d_lane[k] <= d_lane[k-1];
         end

         lane_out       <= lane_next;
         lane_out_valid <= d_valid[PIPE_DLY];
         eof_sent       <= eof_next;
         split_err      <= split_next;
         start_send     <= start_next;
      end
   end

endmodule

// File: doc/jpeg_lane_inserter.md
Name: jpeg_lane_inserter

Overview:
- Single-clock, parametrised successor to the JPEG-to-Ethernet bridge.
- Buffers JPEG bytes in an internal synchronous FIFO, then substitutes them into the user-data slots of a MAC transmit lane stream.
- Supports 4-bit (MII/RMII nibble) and 8-bit (GMII byte) lanes, end-of-image tail flush, underflow padding and status counters.
- Sits between the post-CDC JPEG byte stream and the Ethernet TX framer, in the eth_clk domain.

Parameters:
- LANE_W, 4, lane width; legal values 4 or 8 only.
- DEPTH_LOG2, 12, FIFO depth = 2**DEPTH_LOG2 entries of 9 bits (data + eof flag).
- START_THRESH, 1024, fill level at or above which a frame send is requested.
- PIPE_DLY, 2, lane-input delay stages before substitution; minimum 2.
- PAD_BYTE, 8'h00, byte substituted on underflow.

Ports:
- eth_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  JPEG byte strobe; accepted when in_valid & in_ready.
- in_data  in  8  JPEG byte.
- in_eof  in  1  marks the last byte of an image; qualified by in_valid.
- in_ready  out  1  =!full, combinational from the FIFO count.
- lane_in  in  LANE_W  framer lane data.
- lane_user  in  1  this lane word is a payload slot.
- lane_valid  in  1  frame-active qualifier.
- start_send  out  1  request to the framer to begin a frame.
- lane_out  out  LANE_W  lane data with payload substituted.
- lane_out_valid  out  1  delayed lane_valid.
- eof_sent  out  1  one-cycle pulse when the final lane word of an eof byte is emitted.
- split_err  out  1  one-cycle pulse when a frame ends mid-byte.
- underflow_cnt  out  16  saturating count of PAD_BYTE insertions.
- fill_level  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - start_send=0, lane_out=0, lane_out_valid=0, eof_sent=0, split_err=0, underflow_cnt=0, fill_level=0, in_ready=1.
  - FIFO, eof-pending counter and nibble phase all cleared.
- Write side: a write pushes {in_eof,in_data}. A write while full is impossible because in_ready=0; in_valid during full is ignored with no state change.
- Lane pipeline: lane_in, lane_user and lane_valid pass through PIPE_DLY register stages (d[k]). lane_out and lane_out_valid are registered from d[PIPE_DLY], so total latency is PIPE_DLY+1 cycles.
- Substitution:
  - If d[PIPE_DLY].user=0, lane_out=d[PIPE_DLY].lane.
  - LANE_W=8: each user slot emits one byte.
  - LANE_W=4: each byte spans two user slots, low nibble first, then high nibble. A phase bit toggles on every user slot.
  - The head byte is dequeued at phase 0 (or every slot for LANE_W=8). Dequeue is issued at stage d[PIPE_DLY-1] so the head register is valid at substitution.
- Underflow: if the FIFO is empty when a byte is needed, emit PAD_BYTE (both nibbles) and increment underflow_cnt once per padded byte, saturating at 16'hFFFF. No dequeue occurs.
- Phase:
  - Persists across non-user words within a frame.
  - Cleared on a falling edge of d[PIPE_DLY].valid.
  - If phase=1 at that falling edge, the high nibble is lost and split_err pulses for one cycle.
- eof tracking:
  - eof_pend counts eof-flagged entries in the FIFO: increment on an eof write, decrement on an eof dequeue. Simultaneous increment and decrement leave it unchanged.
  - eof_sent pulses on the cycle lane_out carries the last lane word of an eof byte.
- start_send: registered; =1 when d[PIPE_DLY].valid=0 and (fill_level>=START_THRESH or eof_pend!=0), otherwise 0. The eof_pend term guarantees an image tail below threshold is flushed.
- Simultaneous write and dequeue: fill_level is unchanged. A write into an empty FIFO is dequeuable no earlier than the following cycle.
- Reset mid-frame: all state is cleared on the next edge and buffered data is discarded. lane_out_valid=0 until PIPE_DLY+1 cycles after a lane_valid arrives post-reset.

Test Plan:
- LANE_W=4: push bytes 8'hA5, 8'h3C, then a frame with 4 user slots → lane_out user nibbles 5,A,C,3 at latency PIPE_DLY+1; fill_level returns 0.
- LANE_W=8: push 3 bytes 8'h11, 8'h22, 8'h33, then a frame with 5 user slots → 11,22,33,00,00; underflow_cnt=2.
- Fill to START_THRESH-1 with lane_valid=0 → start_send=0. One more byte → start_send=1 on the next cycle.
- Push 10 bytes, last with in_eof=1 (below threshold) → start_send=1. Emitting the last byte's high nibble → eof_sent pulses once; start_send drops after eof_pend=0.
- LANE_W=4: frame with 3 user slots, FIFO holding 8'hF0 and 8'h0F → nibbles 0,F,F. split_err pulses at frame end; the next frame starts at phase 0 with the next byte.
- Fill to 2**DEPTH_LOG2 → in_ready=0 and extra in_valid is ignored. Assert rst mid-frame → all outputs at reset values; in_ready=1 the next cycle.
